fft_peak_finder: RTL

//  Downstream of the tuner FFT core. Consumes one Avalon-ST complex frame (sop..eop) per transform.

---
 rtl/fft_peak_pkg.sv | 9 +
 rtl/fft_mag_sq.sv | 38 +++
 rtl/fft_peak_finder.sv | 95 +++++++++
 3 files changed

// File: rtl/fft_peak_pkg.sv
// fft_peak_pkg: shared widths and types for the FFT peak finder.
package fft_peak_pkg;
   localparam int DATA_W = 12;
   localparam int PTS_W = 13;
   localparam int BIN_W = 12;
   localparam int MAG_W = 2*DATA_W+1;
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
   typedef logic [MAG_W-1:0] mag_t;
endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: two-stage pipelined re^2+im^2 carrying a valid/bin-index side-band.
module fft_mag_sq
   import fft_peak_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr_i,
   input  logic                     valid_i,
   input  logic [PTS_W-1:0]         k_i,
   input  logic signed [DATA_W-1:0] re_i,
   input  logic signed [DATA_W-1:0] im_i,
   output logic                     valid_o,
   output logic [PTS_W-1:0]         k_o,
   output mag_t                     mag_o
);
   localparam int P_W = 2*DATA_W;
   logic signed [P_W-1:0] re_x, im_x, pre_q, pim_q;
   logic [PTS_W-1:0] k1_q;
   logic v1_q;
   assign re_x = P_W'(re_i);
   assign im_x = P_W'(im_i);
   // clr_i drops the in-flight second-stage result when a frame is restarted
   always_ff @(posedge clk)
      if (reset) begin
         v1_q <= 1'b0;
         valid_o <= 1'b0;
      end else begin
         v1_q <= valid_i;
         valid_o <= v1_q & ~clr_i;
      end
   always_ff @(posedge clk) begin
      k1_q <= k_i;
      pre_q <= re_x * re_x;
      pim_q <= im_x * im_x;
      k_o <= k1_q;
      mag_o <= {1'b0, pre_q} + {1'b0, pim_q};
   end
endmodule

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: per-frame peak |X[k]|^2 search over bins 1..N/2-1.
// FFT_PEAK_GATE_EN adds a threshold input and a peak_none flag.
module fft_peak_finder
   import fft_peak_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sink_valid,
   output logic                     sink_ready,
   input  logic [1:0]               sink_error,
   input  logic                     sink_sop,
   input  logic                     sink_eop,
   input  logic signed [DATA_W-1:0] sink_real,
   input  logic signed [DATA_W-1:0] sink_imag,
   input  logic [PTS_W-1:0]         fftpts_in,
   output logic                     peak_valid,
   input  logic                     peak_ready,
   output logic [BIN_W-1:0]         peak_bin,
   output mag_t                     peak_mag,
   output logic                     peak_error
`ifdef FFT_PEAK_GATE_EN
   ,
   input  mag_t                     thresh,
   output logic                     peak_none
`endif
);
   state_t state_q, state_d;
   logic [PTS_W-1:0] n_q, n_d, k_q, k_d, kk, n_cur, k2, maxk_q, maxk_d;
   logic [1:0] cnt_q, cnt_d;
   logic err_q, err_d, beat, start, in_frame, last, cand, err_beat, load, v2, upd;
   mag_t max_q, max_d, mag2;
   assign sink_ready = state_q != DONE;
   assign peak_valid = state_q == DONE;
   fft_mag_sq u_mag (
      .clk(clk), .reset(reset), .clr_i(start), .valid_i(cand), .k_i(kk),
      .re_i(sink_real), .im_i(sink_imag), .valid_o(v2), .k_o(k2), .mag_o(mag2)
   );
   // k saturates at N-1 so beats past a missing eop never become candidates
   always_comb begin
      beat = sink_valid & sink_ready;
      start = beat & sink_sop & (state_q == IDLE || state_q == SCAN);
      in_frame = start | (beat & state_q == SCAN);
      n_cur = start ? fftpts_in : n_q;
      kk = start ? '0 : k_q;
      last = kk == n_cur - 1'b1;
      cand = in_frame & (kk != '0) & (kk < (n_cur >> 1));
      err_beat = in_frame & ((sink_error != '0) | (sink_eop ^ last));
      n_d = n_cur;
      k_d = (in_frame & ~last) ? kk + 1'b1 : kk;
      err_d = (start ? 1'b0 : err_q) | err_beat;
      load = state_q == DRAIN && cnt_q == 2'd2;
      cnt_d = state_q == DRAIN ? cnt_q + 1'b1 : '0;
      state_d = (in_frame & sink_eop) ? DRAIN :
                start ? SCAN :
                load ? DONE :
                (state_q == DONE && peak_ready) ? IDLE : state_q;
      upd = v2 && mag2 > max_q;
      max_d = start ? '0 : upd ? mag2 : max_q;
      maxk_d = start ? PTS_W'(1) : upd ? k2 : maxk_q;
   end
   always_ff @(posedge clk)
      if (reset) begin
         state_q <= IDLE;
         n_q <= '0;
         k_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
         max_q <= '0;
         maxk_q <= PTS_W'(1);
         peak_bin <= '0;
         peak_mag <= '0;
         peak_error <= 1'b0;
`ifdef FFT_PEAK_GATE_EN
         peak_none <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         n_q <= n_d;
         k_q <= k_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
         max_q <= max_d;
         maxk_q <= maxk_d;
         if (load) begin
            peak_mag <= max_q;
            peak_error <= err_q;
`ifdef FFT_PEAK_GATE_EN
            peak_none <= max_q < thresh;
            peak_bin <= (max_q < thresh) ? '0 : BIN_W'(maxk_q);
`else
            peak_bin <= BIN_W'(maxk_q);
`endif
         end
      end
endmodule
